// File: rtl/cache_control_nway_if.sv
// CPU-side, array-strobe and line-transfer signals of the N-way cache controller.
// The master side is the CPU/datapath; the slave side is the controller.
interface cache_control_nway_if #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned WAY_BITS = $clog2(WAYS),
  parameter int unsigned CNT_W    = 16
);
  logic                mem_read;
  logic                mem_write;
  logic                mem_resp;
  logic [WAYS-1:0]     hit_vec;
  logic [WAYS-1:0]     valid_vec;
  logic [WAYS-1:0]     dirty_vec;
  logic [WAY_BITS-1:0] lru_way;
  logic                lru_update;
  logic [WAY_BITS-1:0] mru_way;
  logic [WAY_BITS-1:0] victim_way;
  logic [WAYS-1:0]     load_tag;
  logic [WAYS-1:0]     load_valid;
  logic [WAYS-1:0]     load_data;
  logic [WAYS-1:0]     load_dirty;
  logic                dirty_in;
  logic                datastore_in_mux_sel;
  logic                pmem_address_mux_sel;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_resp;
  logic                count_clr;
  logic [CNT_W-1:0]    hit_count;
  logic [CNT_W-1:0]    miss_count;

  modport master (
    output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, lru_way,
           pmem_resp, count_clr,
    input  mem_resp, lru_update, mru_way, victim_way, load_tag, load_valid,
           load_data, load_dirty, dirty_in, datastore_in_mux_sel,
           pmem_address_mux_sel, pmem_read, pmem_write, hit_count, miss_count
  );

  modport slave (
    input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, lru_way,
           pmem_resp, count_clr,
    output mem_resp, lru_update, mru_way, victim_way, load_tag, load_valid,
           load_data, load_dirty, dirty_in, datastore_in_mux_sel,
           pmem_address_mux_sel, pmem_read, pmem_write, hit_count, miss_count
  );
endinterface

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back/write-allocate cache:
// hit handling, victim selection, writeback/fill sequencing and hit/miss statistics.
module cache_control_nway #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned WAY_BITS = $clog2(WAYS),
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_control_nway_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t              state;
  logic [WAY_BITS-1:0] victim_q;
  logic                miss_pending;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]    miss_cnt_q;

  logic [WAY_BITS-1:0] hit_way_c;
  logic [WAY_BITS-1:0] inv_way_c;
  logic [WAY_BITS-1:0] miss_victim_c;
  logic                hit_any_c;
  logic                inv_any_c;
  logic                req_c;
  logic                victim_dirty_c;
  logic                miss_c;
  logic                hit_inc_c;

  // Lowest-index hit way and lowest-index invalid way.
  always_comb begin
    hit_way_c = '0;
    inv_way_c = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit_vec[i])    hit_way_c = WAY_BITS'(i);
      if (!bus.valid_vec[i]) inv_way_c = WAY_BITS'(i);
    end
  end

  assign hit_any_c      = |bus.hit_vec;
  assign inv_any_c      = ~&bus.valid_vec;
  assign miss_victim_c  = inv_any_c ? inv_way_c : bus.lru_way;
  assign victim_dirty_c = bus.valid_vec[miss_victim_c] & bus.dirty_vec[miss_victim_c];
  assign req_c          = bus.mem_read | bus.mem_write;
  assign miss_c         = (state == IDLE) && req_c && !hit_any_c;
  assign hit_inc_c      = bus.mem_resp & ~miss_pending;

  assign bus.victim_way = victim_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

  // State, victim latch, miss tracking and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      victim_q     <= '0;
      miss_pending <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_c) begin
            victim_q     <= miss_victim_c;
            miss_pending <= 1'b1;
            state        <= victim_dirty_c ? WRITEBACK : FILL;
          end else if (bus.mem_resp || !req_c) begin
            miss_pending <= 1'b0;
          end
        end
        WRITEBACK: if (bus.pmem_resp) state <= FILL;
        FILL:      if (bus.pmem_resp) state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (bus.count_clr) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        if (hit_inc_c && (hit_cnt_q != '1))  hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
        if (miss_c && (miss_cnt_q != '1))    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Strobes are forced low while reset is held, even if a hit is presented.
  always_comb begin
    bus.mem_resp             = 1'b0;
    bus.lru_update           = 1'b0;
    bus.mru_way              = '0;
    bus.load_tag             = '0;
    bus.load_valid           = '0;
    bus.load_data            = '0;
    bus.load_dirty           = '0;
    bus.dirty_in             = 1'b0;
    bus.datastore_in_mux_sel = 1'b0;
    bus.pmem_address_mux_sel = 1'b0;
    bus.pmem_read            = 1'b0;
    bus.pmem_write           = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req_c && hit_any_c) begin
            bus.mem_resp   = 1'b1;
            bus.lru_update = 1'b1;
            bus.mru_way    = hit_way_c;
            if (bus.mem_write) begin
              bus.load_data[hit_way_c]  = 1'b1;
              bus.load_dirty[hit_way_c] = 1'b1;
              bus.dirty_in              = 1'b1;
              bus.datastore_in_mux_sel  = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write           = 1'b1;
          bus.pmem_address_mux_sel = 1'b1;
        end
        FILL: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.load_data[victim_q]  = 1'b1;
            bus.load_tag[victim_q]   = 1'b1;
            bus.load_valid[victim_q] = 1'b1;
            bus.load_dirty[victim_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Scoreboard bench for cache_control_nway: a single-set cache model drives the
// tag/valid/dirty/LRU inputs and predicts every response, writeback and fill.
module tb_cache_control_nway;
  localparam int unsigned WAYS  = 4;
  localparam int          SAT_L = 65535;
  localparam int          SAT_S = 3;

  typedef struct {
    int kind;   // 0 response, 1 writeback done, 2 fill done
    int way;
    bit wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_control_nway_if #(.WAYS(WAYS), .CNT_W(16)) bus ();
  cache_control_nway_if #(.WAYS(WAYS), .CNT_W(2))  bus_s ();

  cache_control_nway #(.WAYS(WAYS), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  cache_control_nway #(.WAYS(WAYS), .CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  assign bus_s.mem_read  = bus.mem_read;
  assign bus_s.mem_write = bus.mem_write;
  assign bus_s.hit_vec   = bus.hit_vec;
  assign bus_s.valid_vec = bus.valid_vec;
  assign bus_s.dirty_vec = bus.dirty_vec;
  assign bus_s.lru_way   = bus.lru_way;
  assign bus_s.pmem_resp = bus.pmem_resp;
  assign bus_s.count_clr = bus.count_clr;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  // Single-set cache model, LRU order kept as a list (front = least recent).
  int tag_m[WAYS];
  bit valid_m[WAYS];
  bit dirty_m[WAYS];
  int lru_q[$];
  int hit_m  = 0;
  int miss_m = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic exp_t mk(input int kind, input int way, input bit wr);
    exp_t e;
    e.kind = kind;
    e.way  = way;
    e.wr   = wr;
    return e;
  endfunction

  task automatic touch(input int w);
    foreach (lru_q[i]) if (lru_q[i] == w) begin lru_q.delete(i); break; end
    lru_q.push_back(w);
  endtask

  task automatic drive_vecs(input int t);
    logic [3:0] hv, vv, dv;
    for (int i = 0; i < WAYS; i++) begin
      hv[i] = valid_m[i] && (tag_m[i] == t);
      vv[i] = valid_m[i];
      dv[i] = dirty_m[i];
    end
    bus.hit_vec   = hv;
    bus.valid_vec = vv;
    bus.dirty_vec = dv;
    bus.lru_way   = 2'(lru_q[0]);
  endtask

  task automatic check_counts();
    chk("hit_count",      bus.hit_count,    sat(hit_m, SAT_L));
    chk("miss_count",     bus.miss_count,   sat(miss_m, SAT_L));
    chk("sat_hit_count",  bus_s.hit_count,  sat(hit_m, SAT_S));
    chk("sat_miss_count", bus_s.miss_count, sat(miss_m, SAT_S));
  endtask

  // One line-transfer wait; lru_way wanders to prove the victim is latched.
  task automatic pmem_phase(input int waits);
    int n;
    n = (waits < 0) ? int'($urandom_range(0, 4)) : waits;
    repeat (n) begin
      @(posedge clk); #1;
      bus.lru_way = 2'($urandom_range(0, 3));
    end
    bus.pmem_resp = 1'b1;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
  endtask

  task automatic txn(input bit wr, input int t, input bit drop, input bit clr, input int waits);
    int hw, v;
    bit wb;
    hw = -1;
    for (int i = 0; i < WAYS; i++) if (valid_m[i] && tag_m[i] == t) hw = i;
    drive_vecs(t);
    bus.mem_write = wr;
    bus.mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.count_clr = clr;
    if (hw >= 0) begin
      exp_q.push_back(mk(0, hw, wr));
      @(posedge clk); #1;
      if (clr) begin hit_m = 0; miss_m = 0; end else hit_m++;
      touch(hw);
      if (wr) dirty_m[hw] = 1'b1;
    end else begin
      v = -1;
      for (int i = WAYS - 1; i >= 0; i--) if (!valid_m[i]) v = i;
      if (v < 0) v = lru_q[0];
      wb = valid_m[v] && dirty_m[v];
      if (wb) exp_q.push_back(mk(1, v, 1'b0));
      exp_q.push_back(mk(2, v, 1'b0));
      @(posedge clk); #1;
      bus.count_clr = 1'b0;
      if (clr) begin hit_m = 0; miss_m = 0; end else miss_m++;
      if (drop) begin bus.mem_read = 1'b0; bus.mem_write = 1'b0; end
      bus.hit_vec = '0;
      if (wb) pmem_phase(waits);
      pmem_phase(waits);
      tag_m[v] = t; valid_m[v] = 1'b1; dirty_m[v] = 1'b0;
      if (!drop) begin
        drive_vecs(t);
        exp_q.push_back(mk(0, v, wr));
        @(posedge clk); #1;
        touch(v);
        if (wr) dirty_m[v] = 1'b1;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.count_clr = 1'b0;
    bus.hit_vec   = '0;
    check_counts();
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every response / completed line transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic int kind = -1;
      automatic exp_t e;
      automatic logic [3:0] oh;
      if (bus.mem_resp) kind = 0;
      else if (bus.pmem_resp && bus.pmem_write) kind = 1;
      else if (bus.pmem_resp && bus.pmem_read) kind = 2;
      if (bus.pmem_read && !bus.pmem_resp)
        chk("fill_wait_strobes", {bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty}, 0);
      if (kind >= 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", kind, 99);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'(1) << e.way;
          chk("event_kind", kind, e.kind);
          case (e.kind)
            0: begin
              chk("mru_way",    bus.mru_way, e.way);
              chk("lru_update", bus.lru_update, 1);
              chk("resp_load_data",  bus.load_data,  e.wr ? oh : 4'd0);
              chk("resp_load_dirty", bus.load_dirty, e.wr ? oh : 4'd0);
              chk("resp_load_tag",   {bus.load_tag, bus.load_valid}, 0);
              chk("resp_dirty_in",   {bus.dirty_in, bus.datastore_in_mux_sel}, e.wr ? 2'b11 : 2'b00);
            end
            1: begin
              chk("wb_victim_way", bus.victim_way, e.way);
              chk("wb_addr_sel",   bus.pmem_address_mux_sel, 1);
              chk("wb_strobes",    {bus.load_data, bus.load_tag, bus.mem_resp}, 0);
            end
            default: begin
              chk("fill_victim_way", bus.victim_way, e.way);
              chk("fill_addr_sel",   bus.pmem_address_mux_sel, 0);
              chk("fill_strobes", {bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty},
                  {oh, oh, oh, oh});
              chk("fill_dirty_in", {bus.dirty_in, bus.datastore_in_mux_sel, bus.mem_resp}, 0);
            end
          endcase
        end
      end
    end
  end

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit_vec = '0; bus.valid_vec = '0;
    bus.dirty_vec = '0; bus.lru_way = '0; bus.pmem_resp = 1'b0; bus.count_clr = 1'b0;
    for (int i = 0; i < WAYS; i++) begin tag_m[i] = -1; valid_m[i] = 1'b0; dirty_m[i] = 1'b0; end
    lru_q = {0, 1, 2, 3};

    #12;
    chk("rst_outputs", {bus.mem_resp, bus.lru_update, bus.pmem_read, bus.pmem_write, bus.load_data}, 0);
    chk("rst_victim", bus.victim_way, 0);
    check_counts();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Read hit on way 2.
    for (int i = 0; i < WAYS; i++) begin tag_m[i] = 10 + i; valid_m[i] = 1'b1; end
    txn(1'b0, 12, 1'b0, 1'b0, -1);

    // Clear, then write miss with dirty LRU victim 1 (writeback path).
    bus.count_clr = 1'b1; @(posedge clk); #1; bus.count_clr = 1'b0;
    hit_m = 0; miss_m = 0;
    check_counts();
    dirty_m[1] = 1'b1; lru_q = {1, 0, 2, 3};
    txn(1'b1, 20, 1'b0, 1'b0, -1);

    // Read miss with way 2 invalid: straight to fill on way 2.
    valid_m[2] = 1'b0;
    txn(1'b0, 30, 1'b0, 1'b0, 2);

    // Long pmem waits with wandering lru_way, request dropped mid-miss.
    dirty_m[lru_q[0]] = 1'b1;
    txn(1'b0, 40, 1'b1, 1'b0, 5);

    // Saturate the narrow counters, then clear on a simultaneous hit.
    repeat (5) txn(1'($urandom_range(0, 1)), tag_m[0], 1'b0, 1'b0, -1);
    txn(1'b0, tag_m[1], 1'b0, 1'b1, -1);

    // Random traffic over a small tag pool.
    repeat (150) begin
      automatic int r = int'($urandom_range(0, 15));
      txn(1'($urandom_range(0, 1)), 100 + int'($urandom_range(0, 7)), r == 0, r == 1, -1);
    end

    // Asynchronous reset while in FILL.
    valid_m[0] = 1'b0;
    drive_vecs(500);
    bus.mem_read = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_fill", bus.pmem_read, 1);
    @(posedge clk); #3;
    bus.hit_vec = 4'b0001;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {bus.pmem_read, bus.pmem_write, bus.mem_resp, bus.lru_update, bus.load_data}, 0);
    chk("rst_async_victim", bus.victim_way, 0);
    exp_q.delete();
    hit_m = 0; miss_m = 0;
    check_counts();
    bus.mem_read = 1'b0; bus.hit_vec = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {bus.pmem_read, bus.pmem_write}, 0);
    txn(1'b0, tag_m[1], 1'b0, 1'b0, -1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
